// File: rtl/video_linebuf_writer.sv
// Fills the idle scanline bank from the renderer pixel stream, ping-ponging banks on start_of_line.
// Write latency 1 cycle after accept; pix_ready drops on the swap cycle and outside STREAM.
module video_linebuf_writer #(
  parameter int H_ACTIVE = 640,
  parameter int V_ACTIVE = 480,
  parameter int V_TOTAL  = 525
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_start_of_line,
  input  logic        i_start_of_screen,
  output logic        o_display_bank,
  output logic [10:0] o_linebuf_wr_idx,
  output logic [11:0] o_linebuf_wr_data,
  output logic        o_linebuf_wr_en,
  output logic        o_pix_line_req,
  output logic [8:0]  o_pix_line,
  output logic        o_pix_abort,
  input  logic        i_pix_valid,
  input  logic [11:0] i_pix_data,
  output logic        o_pix_ready,
  output logic        o_underrun,
  input  logic        i_underrun_clr
);

  localparam int XW = 10;
  localparam int LW = 10;

  typedef enum logic [1:0] {IDLE, REQ, STREAM, DONE} state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic            r_display_bank;
  logic [LW-1:0]   r_display_line;
  logic [XW-1:0]   r_x;
  logic            r_wr_en;
  logic [10:0]     r_wr_idx;
  logic [11:0]     r_wr_data;
  logic            r_line_req;
  logic [8:0]      r_pix_line;
  logic            r_underrun;

  logic [LW-1:0]   w_next_line;
  logic [LW-1:0]   w_render_line;
  logic            w_render_vis;
  logic            w_ready;
  logic            w_accept;
  logic            w_abort;
  logic            w_last_pix;

  always_comb begin
    w_next_line = '0;
    if (!i_start_of_screen && (r_display_line != LW'(V_TOTAL - 1)))
      w_next_line = r_display_line + 1'b1;
    // Render one line ahead of the line about to be displayed.
    w_render_line = (w_next_line == LW'(V_TOTAL - 1)) ? '0 : w_next_line + 1'b1;
    w_render_vis  = (w_render_line < LW'(V_ACTIVE));
    w_ready       = (r_state == STREAM) && !i_start_of_line;
    w_accept      = w_ready && i_pix_valid;
    w_abort       = i_start_of_line && ((r_state == REQ) || (r_state == STREAM));
    w_last_pix    = (r_x == XW'(H_ACTIVE - 1));
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    if (i_start_of_line) begin
      w_state_nxt = w_render_vis ? REQ : IDLE;
    end else begin
      case (r_state)
        REQ:     w_state_nxt = STREAM;
        STREAM:  if (w_accept && w_last_pix) w_state_nxt = DONE;
        default: w_state_nxt = r_state;
      endcase
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_display_bank <= 1'b0;
      r_display_line <= '0;
      r_x            <= '0;
      r_wr_en        <= 1'b0;
      r_wr_idx       <= '0;
      r_wr_data      <= '0;
      r_line_req     <= 1'b0;
      r_pix_line     <= '0;
      r_underrun     <= 1'b0;
    end else begin
      r_line_req <= 1'b0;
      r_wr_en    <= w_accept;
      if (i_start_of_line) begin
        r_display_bank <= ~r_display_bank;
        r_display_line <= w_next_line;
        if (w_render_vis) begin
          r_line_req <= 1'b1;
          r_pix_line <= w_render_line[8:0];
        end
      end
      if (r_state == REQ) r_x <= '0;
      // Bank is sampled at accept; a write trailing a swap still lands in the old bank.
      if (w_accept) begin
        r_wr_idx  <= {~r_display_bank, r_x};
        r_wr_data <= i_pix_data;
        if (!w_last_pix) r_x <= r_x + 1'b1;
      end
      if (w_abort)             r_underrun <= 1'b1;
      else if (i_underrun_clr) r_underrun <= 1'b0;
    end
  end

  assign o_display_bank    = r_display_bank;
  assign o_linebuf_wr_idx  = r_wr_idx;
  assign o_linebuf_wr_data = r_wr_data;
  assign o_linebuf_wr_en   = r_wr_en;
  assign o_pix_line_req    = r_line_req;
  assign o_pix_line        = r_pix_line;
  assign o_pix_abort       = w_abort;
  assign o_pix_ready       = w_ready;
  assign o_underrun        = r_underrun | w_abort;

endmodule

// File: tb/tb_video_linebuf_writer.sv
// Randomized scoreboard bench for video_linebuf_writer with a line-level reference model.
module tb_video_linebuf_writer;

  logic        clk = 1'b0;
  logic        rst;
  logic        sol, sos, clr, pvld;
  logic [11:0] pdat;
  logic        disp_bank, wr_en, line_req, abort_o, pready, underrun;
  logic [10:0] wr_idx;
  logic [11:0] wr_data;
  logic [8:0]  pix_line;

  always #5 clk = ~clk;

  video_linebuf_writer dut (
    .i_clk(clk), .i_rst(rst),
    .i_start_of_line(sol), .i_start_of_screen(sos),
    .o_display_bank(disp_bank),
    .o_linebuf_wr_idx(wr_idx), .o_linebuf_wr_data(wr_data), .o_linebuf_wr_en(wr_en),
    .o_pix_line_req(line_req), .o_pix_line(pix_line), .o_pix_abort(abort_o),
    .i_pix_valid(pvld), .i_pix_data(pdat), .o_pix_ready(pready),
    .o_underrun(underrun), .i_underrun_clr(clr)
  );

  int n_cmp = 0;
  int n_err = 0;

  logic [22:0] q_wr[$];
  logic [8:0]  q_req[$];
  bit          q_abort[$];
  bit          q_bank[$];

  int  m_line, k, n_wr_seen, n_req_seen;
  bit  m_bank, m_active, taken, data_is_x, prev_sol;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic fail_evt(input string nm);
    n_cmp++;
    n_err++;
    $display("FAIL %s: unexpected event at %0t", nm, $time);
  endtask

  // Monitor: pops expectations whenever the DUT presents an output event.
  always @(negedge clk) begin
    if (rst) begin
      if (wr_en) fail_evt("write_during_reset");
      prev_sol = 1'b0;
    end else begin
      if (wr_en) begin
        n_wr_seen++;
        if (q_wr.size() == 0) fail_evt("write");
        else chk("write", {wr_idx, wr_data}, q_wr.pop_front());
      end
      if (line_req) begin
        n_req_seen++;
        if (q_req.size() == 0) fail_evt("line_req");
        else chk("pix_line", pix_line, q_req.pop_front());
      end
      if (sol) begin
        if (q_abort.size() != 0) begin
          automatic bit ea = q_abort.pop_front();
          chk("abort", abort_o, ea);
          chk("ready_on_swap", pready, 0);
          if (ea) chk("underrun_on_abort", underrun, 1);
        end
      end else if (abort_o) begin
        fail_evt("abort_without_sol");
      end
      if (prev_sol && q_bank.size() != 0) chk("display_bank", disp_bank, q_bank.pop_front());
      prev_sol = sol;
    end
  end

  task automatic model_reset();
    m_line = 0; m_bank = 0; m_active = 0; k = 0; taken = 0;
    q_wr.delete(); q_req.delete(); q_abort.delete(); q_bank.delete();
  endtask

  // One clock: drive inputs, update the line model, then record any handshake.
  task automatic cycle(input bit s_ol, input bit s_os, input bit c_lr, input int duty);
    int r;
    if (taken) begin pvld = 1'b0; taken = 1'b0; end
    sol = s_ol; sos = s_os & s_ol; clr = c_lr;
    if (s_ol) begin
      q_abort.push_back(m_active);
      m_bank = !m_bank;
      q_bank.push_back(m_bank);
      m_line = s_os ? 0 : (m_line + 1) % 525;
      r = (m_line + 1) % 525;
      if (r < 480) begin
        q_req.push_back(9'(r));
        m_active = 1; k = 0;
      end else begin
        m_active = 0;
      end
      pvld = 1'b0;
    end else if (m_active && k < 640 && !pvld) begin
      if ($urandom_range(99) < duty) begin
        pvld = 1'b1;
        pdat = data_is_x ? 12'(k) : 12'($urandom);
      end
    end
    @(negedge clk);
    if (pvld && pready && !rst) begin
      q_wr.push_back({~m_bank, 10'(k), pdat});
      k++;
      if (k == 640) m_active = 0;
      taken = 1'b1;
    end
    @(posedge clk);
    #1;
    sol = 1'b0; sos = 1'b0; clr = 1'b0;
  endtask

  task automatic stream_line(input string nm, input int duty);
    int w0;
    w0 = n_wr_seen;
    for (int i = 0; i < 4000 && m_active; i++) cycle(0, 0, 0, duty);
    chk({nm, "_delivered"}, m_active, 0);
    repeat (2) cycle(0, 0, 0, 0);
    chk({nm, "_write_count"}, n_wr_seen - w0, 640);
    chk({nm, "_ready_after_done"}, pready, 0);
  endtask

  initial begin
    int r0;
    rst = 1'b1; sol = 0; sos = 0; clr = 0; pvld = 0; pdat = '0;
    data_is_x = 0; n_wr_seen = 0; n_req_seen = 0; prev_sol = 0;
    model_reset();
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    chk("rst_display_bank", disp_bank, 0);
    chk("rst_wr_en", wr_en, 0);
    chk("rst_line_req", line_req, 0);
    chk("rst_abort", abort_o, 0);
    chk("rst_underrun", underrun, 0);
    chk("rst_wr_idx", wr_idx, 0);
    chk("rst_wr_data", wr_data, 0);
    chk("rst_pix_line", pix_line, 0);
    chk("rst_ready", pready, 0);

    // First line after screen start, data equals pixel index.
    data_is_x = 1;
    cycle(1, 1, 0, 0);
    chk("bank_after_sos", disp_bank, 1);
    chk("wr_en_before_valid", wr_en, 0);
    stream_line("line_x", 100);
    chk("underrun_clean", underrun, 0);
    data_is_x = 0;

    // Random-gap lines.
    for (int l = 0; l < 3; l++) begin
      cycle(1, 0, 0, 0);
      stream_line("line_rand", 50);
    end
    chk("underrun_still_clean", underrun, 0);

    // Source stalls mid-line, swap arrives.
    cycle(1, 0, 0, 0);
    for (int i = 0; i < 1000 && k < 100; i++) cycle(0, 0, 0, 100);
    repeat (10) cycle(0, 0, 0, 0);
    cycle(1, 0, 0, 0);
    chk("underrun_sticky", underrun, 1);
    repeat (3) cycle(0, 0, 0, 0);
    cycle(0, 0, 1, 0);
    chk("underrun_cleared", underrun, 0);

    // Full frame of 525 line pulses with no pixels delivered.
    r0 = n_req_seen;
    cycle(1, 1, 0, 0);
    for (int l = 1; l < 525; l++) begin
      repeat (3) cycle(0, 0, 0, 0);
      cycle(1, 0, 0, 0);
    end
    cycle(0, 0, 0, 0);
    chk("frame_requests", n_req_seen - r0, 480);
    chk("frame_req_queue_drained", q_req.size(), 0);
    cycle(1, 0, 0, 0);
    repeat (2) cycle(0, 0, 0, 0);
    chk("wrap_req_drained", q_req.size(), 0);

    // Reset in the middle of a line.
    cycle(1, 0, 0, 0);
    for (int i = 0; i < 1000 && k < 300; i++) cycle(0, 0, 0, 100);
    rst = 1'b1;
    #1;
    chk("midrst_wr_en", wr_en, 0);
    chk("midrst_ready", pready, 0);
    chk("midrst_bank", disp_bank, 0);
    chk("midrst_wr_idx", wr_idx, 0);
    chk("midrst_underrun", underrun, 0);
    @(posedge clk); #1;
    chk("midrst_wr_en_edge", wr_en, 0);
    chk("midrst_line_req", line_req, 0);
    repeat (2) @(posedge clk);
    model_reset();
    pvld = 1'b0;
    #1 rst = 1'b0;
    cycle(1, 0, 0, 0);
    chk("post_rst_bank", disp_bank, 1);
    stream_line("line_post_rst", 70);

    repeat (3) cycle(0, 0, 0, 0);
    chk("end_wr_queue", q_wr.size(), 0);
    chk("end_req_queue", q_req.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/video_linebuf_writer.md
Name: video_linebuf_writer

Overview:
- Producer side of the scanline buffer consumed by the VGA output stage.
- Uses the timing generator's start_of_line / start_of_screen pulses to ping-pong two line banks: the reader displays one bank while this block fills the other.
- Requests one line of pixels from the renderer, accepts the 12-bit RGB pixels over a valid/ready stream, writes them into the idle bank, and flags an underrun when a line is not finished in time.

Parameters:
- H_ACTIVE, 640, pixels written per line.
- V_ACTIVE, 480, visible lines per frame.
- V_TOTAL, 525, total lines per frame, including blanking.

Ports:
- clk  input  1  pixel clock
- rst  input  1  reset; asynchronous, active-high
- start_of_line  input  1  one-cycle pulse on the last clock of every line
- start_of_screen  input  1  one-cycle pulse on the last clock of the frame; always coincident with start_of_line
- display_bank  output  1  bank the reader uses; the reader address is {display_bank, x}
- linebuf_wr_idx  output  11  write address {write_bank, x[9:0]}
- linebuf_wr_data  output  12  RGB 4:4:4 write data
- linebuf_wr_en  output  1  write strobe
- pix_line_req  output  1  one-cycle pulse: start rendering line pix_line
- pix_line  output  9  line number being requested
- pix_abort  output  1  one-cycle pulse: discard the current line
- pix_valid  input  1  pixel available
- pix_data  input  12  pixel RGB
- pix_ready  output  1  pixel accepted when pix_valid && pix_ready
- underrun  output  1  sticky underrun flag
- underrun_clr  input  1  clears underrun

Behaviour:
- Reset values:
  - display_bank=0, display_line=0, state=IDLE, x=0.
  - All outputs 0: linebuf_wr_en, pix_line_req, pix_abort, underrun, and the address/data registers.
- write_bank is always ~display_bank.
- Line tracking, on start_of_line:
  - display_bank toggles.
  - display_line becomes 0 if start_of_screen is also high; otherwise display_line+1, wrapping V_TOTAL-1 -> 0.
  - render_line = (new display_line + 1) mod V_TOTAL.
  - Consequence: line 0 is rendered while line V_TOTAL-1 is displayed.
- States: IDLE, REQ, STREAM, DONE.
- IDLE / DONE:
  - On start_of_line with render_line < V_ACTIVE: go to REQ.
  - Otherwise stay idle (stay in or return to IDLE).
- REQ (one cycle):
  - pix_line_req=1, pix_line=render_line, x=0.
  - Next state: STREAM.
- STREAM:
  - pix_ready = (state==STREAM) && !start_of_line. The ready path is combinational so no pixel is accepted on the swap cycle.
  - Each accepted pixel registers linebuf_wr_en=1, linebuf_wr_idx={write_bank, x}, linebuf_wr_data=pix_data on the next clock (latency 1), then x increments.
  - The accept of pixel x = H_ACTIVE-1 moves the state to DONE.
  - The write address uses the write_bank captured at accept time; the trailing write after a swap still targets the old bank.
- Underrun: start_of_line arriving while in REQ or STREAM:
  - pix_abort pulses in that cycle.
  - underrun is set.
  - The remaining pixels of that bank are left unwritten (stale).
  - The normal start_of_line handling above still applies: a new REQ if render_line < V_ACTIVE, else IDLE.
- underrun_clr clears underrun; if a set and a clear occur in the same cycle, the set wins.
- pix_valid without pix_ready is ignored. The source holds its data until accepted.
- linebuf_wr_en is never high for more than H_ACTIVE cycles per line; x never exceeds H_ACTIVE-1.
- rst asserted mid-line returns everything to reset values immediately. No write is issued after rst is asserted.

Test Plan:
- Reset, then start_of_line+start_of_screen pulse -> display_bank=1, next cycle pix_line_req=1 with pix_line=1; linebuf_wr_en stays 0 until pix_valid.
- Source streams 640 pixels with pix_valid always 1, data = x -> 640 writes at idx 0x000..0x27F (bank 0) with data 0..639; state DONE; underrun=0.
- Random pix_valid gaps (~50% duty), line fully delivered before the next start_of_line -> addresses are contiguous with no duplicates; exactly 640 writes.
- Source stalls after 100 pixels, start_of_line arrives -> pix_abort=1 and underrun=1 in that cycle; pix_ready=0 in that cycle; the next line request is issued; underrun_clr then clears it.
- Run a full frame of 525 start_of_line pulses -> exactly 480 pix_line_req pulses. pix_line goes 1..479, then 0 is requested on the pulse that begins display line 524. No requests during display lines 479..523.
- rst asserted at pixel 300 of a line -> all outputs 0 on the next edge; no further writes; after release the first start_of_line behaves as after a clean reset.
